bpu_ctrl: RTL

Branch-prediction controller wrapping the direct-mapped BTB. It selects the next fetch PC from the BTB lookup, carries each fetched instruction's prediction through ID to EX in shadow registers, and compares it with the resolved outcome. On a mismatch it flushes and redirects the front end, and it sequences BTB writes for resolved taken control transfers. It sits between the IF PC register, the BTB and the EX branch unit, and keeps branch and mispredict performance counters.

---
 rtl/bpu_pkg.sv | 17 +
 rtl/bpu_pred_reg.sv | 31 +++
 rtl/bpu_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// bpu_pkg: types and constants shared by the branch-prediction controller.
//   pred_rec_t   - prediction record carried alongside each fetched instruction
//   PRED_REC_RST - cleared record (invalid, all fields zero)
//   INSN_BYTES   - sequential fetch increment
package bpu_pkg;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_rec_t;

  localparam pred_rec_t PRED_REC_RST = '0;
  localparam int        INSN_BYTES   = 4;

endpackage

// File: rtl/bpu_pred_reg.sv
// bpu_pred_reg: one shadow pipeline stage holding a prediction record.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   flush    - invalidate the held record
//   stall    - hold the current record
//   d        - record from the previous stage
//   q        - record held by this stage
module bpu_pred_reg
  import bpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      stall,
  input  pred_rec_t d,
  output pred_rec_t q
);

  // Flush only drops the valid bit; the stale payload is never looked at
  // while v is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= PRED_REC_RST;
    end else if (flush) begin
      q.v <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bpu_ctrl.sv
// bpu_ctrl: branch-prediction controller around a direct-mapped BTB.
// Picks the next fetch PC, shadows each prediction through ID and EX,
// checks it against the EX outcome, redirects/flushes on a mispredict,
// writes resolved taken transfers to the BTB and counts branches and
// mispredicts.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   pc_if, if_valid                 - current fetch PC and its validity
//   btb_hit_if, btb_target_if       - BTB lookup result for pc_if
//   stall                           - freeze IF/ID and ID/EX
//   ex_is_cf, ex_taken, ex_target   - resolved outcome of the EX instruction
//   trap_en, trap_pc                - trap redirect request and handler address
//   next_pc                         - value for the IF PC register
//   flush                           - kill IF and ID this cycle
//   mispredict                      - EX prediction was wrong
//   btb_update_en/pc_ex/target_ex   - BTB write port
//   perf_br, perf_mispred           - performance counters
module bpu_ctrl
  import bpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_if,
  input  logic             if_valid,
  input  logic             btb_hit_if,
  input  logic [31:0]      btb_target_if,
  input  logic             stall,
  input  logic             ex_is_cf,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             trap_en,
  input  logic [31:0]      trap_pc,
  output logic [31:0]      next_pc,
  output logic             flush,
  output logic             mispredict,
  output logic             btb_update_en,
  output logic [31:0]      btb_pc_ex,
  output logic [31:0]      btb_target_ex,
  output logic [CNT_W-1:0] perf_br,
  output logic [CNT_W-1:0] perf_mispred
);

  pred_rec_t   rec_if;
  pred_rec_t   rec_id;
  pred_rec_t   rec_ex;
  logic        fire;
  logic        act_taken;
  logic [31:0] redirect_pc;

  always_comb begin
    rec_if        = PRED_REC_RST;
    rec_if.v      = if_valid;
    rec_if.pc     = pc_if;
    rec_if.taken  = if_valid & btb_hit_if;
    rec_if.target = btb_target_if;
  end

  bpu_pred_reg u_id (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .d     (rec_if),
    .q     (rec_id)
  );

  bpu_pred_reg u_ex (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .d     (rec_id),
    .q     (rec_ex)
  );

  assign fire        = rec_ex.v & ~stall;
  assign act_taken   = ex_is_cf & ex_taken;
  assign redirect_pc = act_taken ? ex_target : rec_ex.pc + 32'(INSN_BYTES);

  // A non-CF instruction that hit in the BTB was predicted taken, so the
  // direction compare alone catches the alias and sends it to pc+4.
  assign mispredict = fire & ((rec_ex.taken != act_taken) |
                              (act_taken & (rec_ex.target != ex_target)));

  assign flush = trap_en | mispredict;

  always_comb begin
    next_pc = pc_if + 32'(INSN_BYTES);
    if (trap_en) begin
      next_pc = trap_pc;
    end else if (mispredict) begin
      next_pc = redirect_pc;
    end else if (stall) begin
      next_pc = pc_if;
    end else if (if_valid & btb_hit_if) begin
      next_pc = btb_target_if;
    end
  end

  // Not-taken outcomes never invalidate an entry; a stale hit just
  // mispredicts again.
  assign btb_update_en = fire & act_taken & ~trap_en;
  assign btb_pc_ex     = rec_ex.pc;
  assign btb_target_ex = ex_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br      <= '0;
      perf_mispred <= '0;
    end else begin
      if (fire & ex_is_cf & ~trap_en) begin
        perf_br <= perf_br + CNT_W'(1);
      end
      if (mispredict & ~trap_en) begin
        perf_mispred <= perf_mispred + CNT_W'(1);
      end
    end
  end

endmodule
